// File: rtl/player_sprite_pkg.sv
// Shared types and constants for the player sprite fetch path.
package player_sprite_pkg;

  typedef enum logic [1:0] {
    SEL_RUN  = 2'd0,
    SEL_DOWN = 2'd1,
    SEL_JUMP = 2'd2,
    SEL_DEAD = 2'd3
  } sel_t;

  localparam logic [3:0]  KEY_DOWN_R    = 4'h7;
  localparam logic [3:0]  KEY_DOWN_L    = 4'h8;
  localparam int unsigned SPRITE_ADDR_W = 21;
  localparam int unsigned PIX_IDX_W     = 8;
  localparam int unsigned COORD_W       = 10;

  // Animation request priority: death overrides jump overrides crouch.
  function automatic sel_t selRequest(input logic dead, input logic jumping,
                                      input logic [3:0] keycode);
    if (dead)                                          return SEL_DEAD;
    else if (jumping)                                  return SEL_JUMP;
    else if (keycode == KEY_DOWN_R || keycode == KEY_DOWN_L) return SEL_DOWN;
    else                                               return SEL_RUN;
  endfunction

endpackage

// File: rtl/player_sprite_fetch_pipe_delay.sv
// Fixed-depth shift register with synchronous clear, used to align pixel
// side-band data with sprite ROM read latency.
module pipe_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             frame_Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      for (int i = 0; i < int'(DEPTH); i++) taps[i] <= '0;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/player_sprite_fetch.sv
// Player sprite fetch: per-frame animation source select, ROM addressing,
// latency-matched pixel output. Optional blink gating via PLAYER_BLINK_EN.
module player_sprite_fetch
  import player_sprite_pkg::*;
#(
  parameter int unsigned                  ROM_LATENCY     = 2,
  parameter logic [SPRITE_ADDR_W-1:0]     ROM_DEPTH       = 21'd1_200_000,
  parameter logic [PIX_IDX_W-1:0]         TRANSPARENT_IDX = 8'h00,
  parameter int unsigned                  NUM_SRC         = 4
) (
  input  logic                               frame_Clk,
  input  logic                               Reset,
  input  logic [COORD_W-1:0]                 DrawX,
  input  logic [COORD_W-1:0]                 DrawY,
  input  logic [3:0]                         keycode,
  input  logic                               jumping,
  input  logic                               dead,
  input  logic                               invincible,
  input  logic [NUM_SRC-1:0]                 src_on,
  input  logic [NUM_SRC*SPRITE_ADDR_W-1:0]   src_addr,
  output logic [SPRITE_ADDR_W-1:0]           rom_addr,
  input  logic [PIX_IDX_W-1:0]               rom_data,
  output logic [PIX_IDX_W-1:0]               pix_idx,
  output logic                               pix_on,
  output logic [COORD_W-1:0]                 pix_x,
  output logic [COORD_W-1:0]                 pix_y,
  output logic [1:0]                         sel_state
);

  localparam int unsigned PIPE_W = 1 + 2 * COORD_W;

  sel_t                     selState, selNext, pending, reqSel;
  logic [7:0]               frameCnt;
  logic                     frameStart;
  logic [SPRITE_ADDR_W-1:0] selAddr;
  logic                     selOn;
  logic                     v0, vD, blinkOff;
  logic [COORD_W-1:0]       x0, y0, xD, yD;

  assign frameStart = (DrawX == '0) && (DrawY == '0);
  assign selAddr    = src_addr[int'(selState)*SPRITE_ADDR_W +: SPRITE_ADDR_W];
  assign selOn      = src_on[selState];
  assign sel_state  = selState;

  // Select FSM: any-to-any transition, but only at frame start to avoid tearing.
  always_comb begin
    reqSel  = selRequest(dead, jumping, keycode);
    selNext = selState;
    if (frameStart) selNext = pending;
  end

  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      selState <= SEL_RUN;
      pending  <= SEL_RUN;
      frameCnt <= 8'd0;
    end else begin
      selState <= selNext;
      pending  <= reqSel;
      if (frameStart) frameCnt <= frameCnt + 8'd1;
    end
  end

  // Stage 0: address issue; out-of-range words are flagged invalid here.
  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      rom_addr <= '0;
      v0       <= 1'b0;
      x0       <= '0;
      y0       <= '0;
    end else begin
      rom_addr <= selAddr;
      v0       <= selOn && (selAddr < ROM_DEPTH);
      x0       <= DrawX;
      y0       <= DrawY;
    end
  end

  pipe_delay #(
    .WIDTH (PIPE_W),
    .DEPTH (ROM_LATENCY)
  ) u_delay (
    .frame_Clk (frame_Clk),
    .Reset     (Reset),
    .din       ({v0, x0, y0}),
    .dout      ({vD, xD, yD})
  );

`ifdef PLAYER_BLINK_EN
  assign blinkOff = invincible && frameCnt[2];
`else
  assign blinkOff = 1'b0;
`endif

  // Frame counter is kept for debug visibility in both builds.
  logic unusedDebug;
  assign unusedDebug = &{1'b0, invincible, frameCnt};

  // Output stage: ROM data meets its delayed valid/coordinates.
  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      pix_idx <= '0;
      pix_on  <= 1'b0;
      pix_x   <= '0;
      pix_y   <= '0;
    end else begin
      pix_idx <= rom_data;
      pix_on  <= vD && (rom_data != TRANSPARENT_IDX) && !blinkOff;
      pix_x   <= xD;
      pix_y   <= yD;
    end
  end

endmodule

// File: tb/tb_player_sprite_fetch.sv
// Directed self-checking bench for player_sprite_fetch (ROM_LATENCY=2).
module tb_player_sprite_fetch;

  localparam logic [20:0] DEPTH = 21'd1_200_000;

  logic        frame_Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic [3:0]  keycode;
  logic        jumping, dead, invincible;
  logic [3:0]  src_on;
  logic [83:0] src_addr;
  logic [20:0] rom_addr;
  logic [7:0]  rom_data, pix_idx;
  logic        pix_on;
  logic [9:0]  pix_x, pix_y;
  logic [1:0]  sel_state;
  logic [7:0]  romQ1 = 8'h00, romQ2 = 8'h00;
  logic [7:0]  expFrames;
  int          total = 0;
  int          bad = 0;

  always #5 frame_Clk = ~frame_Clk;

  player_sprite_fetch dut (
    .frame_Clk (frame_Clk), .Reset (Reset), .DrawX (DrawX), .DrawY (DrawY),
    .keycode (keycode), .jumping (jumping), .dead (dead), .invincible (invincible),
    .src_on (src_on), .src_addr (src_addr), .rom_addr (rom_addr),
    .rom_data (rom_data), .pix_idx (pix_idx), .pix_on (pix_on),
    .pix_x (pix_x), .pix_y (pix_y), .sel_state (sel_state)
  );

  // ROM model with two-cycle read latency.
  function automatic logic [7:0] romFn(input logic [20:0] a);
    if (a == 21'd100 || a == DEPTH) return 8'h2A;
    if (a == 21'd200) return 8'h00;
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(posedge frame_Clk) begin
    romQ1 <= romFn(rom_addr);
    romQ2 <= romQ1;
  end
  assign rom_data = romQ2;

  task automatic step();
    @(posedge frame_Clk);
    @(negedge frame_Clk);
  endtask

  task automatic setAddr(input int i, input logic [20:0] a);
    src_addr[i*21 +: 21] = a;
  endtask

  task automatic test_reset();
    Reset = 1'b1; DrawX = 10'd5; DrawY = 10'd5; src_on = 4'hF;
    for (int i = 0; i < 4; i++) setAddr(i, 21'd100);
    step(); step();
    total++;
    if ({rom_addr, pix_idx, pix_on, pix_x, pix_y, sel_state} !== 52'd0) begin
      bad++;
      $display("FAIL reset_values got=%h exp=0",
               {rom_addr, pix_idx, pix_on, pix_x, pix_y, sel_state});
    end
    total++;
    if (dut.frameCnt !== 8'd0) begin
      bad++; $display("FAIL reset_frame_cnt got=%0d exp=0", dut.frameCnt);
    end
    Reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if (pix_on !== 1'b0) begin
        bad++; $display("FAIL post_reset_flush cyc=%0d got=%b exp=0", i, pix_on);
      end
    end
    step();
    total++;
    if (pix_on !== 1'b1 || pix_idx !== 8'h2A || pix_x !== 10'd5) begin
      bad++;
      $display("FAIL post_reset_first got on=%b idx=%h x=%0d exp on=1 idx=2a x=5",
               pix_on, pix_idx, pix_x);
    end
    src_on = 4'h0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i >= 3) begin
        total++;
        if (pix_on !== 1'b0 || sel_state !== 2'd0) begin
          bad++;
          $display("FAIL idle got on=%b sel=%0d exp on=0 sel=0", pix_on, sel_state);
        end
      end
    end
  endtask

  task automatic test_latency();
    src_on = 4'b0001;
    setAddr(0, 21'd100); setAddr(1, 21'd300); setAddr(2, 21'd400); setAddr(3, 21'd500);
    DrawX = 10'd50; DrawY = 10'd60;
    step();
    total++;
    if (rom_addr !== 21'd100) begin
      bad++; $display("FAIL lat_rom_addr got=%0d exp=100", rom_addr);
    end
    src_on = 4'b0000; setAddr(0, 21'd7); DrawX = 10'd51; DrawY = 10'd61;
    step();
    total++;
    if (rom_addr !== 21'd7) begin
      bad++; $display("FAIL lat_rom_addr2 got=%0d exp=7", rom_addr);
    end
    step();
    total++;
    if (pix_on !== 1'b0) begin
      bad++; $display("FAIL lat_early got=%b exp=0", pix_on);
    end
    step();
    total++;
    if (pix_idx !== 8'h2A || pix_on !== 1'b1 || pix_x !== 10'd50 || pix_y !== 10'd60) begin
      bad++;
      $display("FAIL lat_out got idx=%h on=%b x=%0d y=%0d exp idx=2a on=1 x=50 y=60",
               pix_idx, pix_on, pix_x, pix_y);
    end
    step();
    total++;
    if (pix_idx !== 8'h5D || pix_on !== 1'b0 || pix_x !== 10'd51 || pix_y !== 10'd61) begin
      bad++;
      $display("FAIL lat_invalid got idx=%h on=%b x=%0d y=%0d exp idx=5d on=0 x=51 y=61",
               pix_idx, pix_on, pix_x, pix_y);
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] addrs [4];
    logic [7:0]  expIdx [4];
    logic        expOn [4];
    addrs  = '{21'd100, 21'd200, DEPTH, DEPTH - 21'd1};
    expIdx = '{8'h2A, 8'h00, 8'h2A, 8'h25};
    expOn  = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin
        src_on = 4'b0001; setAddr(0, addrs[c]);
      end else begin
        src_on = 4'b0000;
      end
      DrawX = 10'(10 + c); DrawY = 10'd20;
      step();
      if (c >= 3) begin
        total++;
        if (pix_on !== expOn[c-3] || pix_idx !== expIdx[c-3] || pix_x !== 10'(7 + c)) begin
          bad++;
          $display("FAIL b2b_%0d got on=%b idx=%h x=%0d exp on=%b idx=%h x=%0d", c - 3,
                   pix_on, pix_idx, pix_x, expOn[c-3], expIdx[c-3], 7 + c);
        end
      end
    end
  endtask

  task automatic test_frame_select();
    logic       reqDead [5];
    logic       reqJump [5];
    logic [3:0] reqKey [5];
    logic [1:0] expSel [5];
    logic [1:0] prevSel;
    reqDead = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    reqJump = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    reqKey  = '{4'h7, 4'h0, 4'h8, 4'h0, 4'h8};
    expSel  = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd1};
    src_on = 4'h0;
    for (int i = 0; i < 4; i++) setAddr(i, 21'(1000 + i));
    expFrames = 8'd0;
    prevSel = 2'd0;
    for (int t = 0; t < 5; t++) begin
      dead = reqDead[t]; jumping = reqJump[t]; keycode = reqKey[t];
      DrawX = 10'd100; DrawY = 10'd200;
      for (int i = 0; i < 3; i++) begin
        step();
        total++;
        if (sel_state !== prevSel) begin
          bad++; $display("FAIL sel_hold_%0d got=%0d exp=%0d", t, sel_state, prevSel);
        end
      end
      DrawX = 10'd0; DrawY = 10'd0;
      step();
      expFrames++;
      total++;
      if (sel_state !== expSel[t] || rom_addr !== 21'(1000 + prevSel) ||
          dut.frameCnt !== expFrames) begin
        bad++;
        $display("FAIL sel_commit_%0d got sel=%0d addr=%0d fc=%0d exp sel=%0d addr=%0d fc=%0d",
                 t, sel_state, rom_addr, dut.frameCnt, expSel[t], 1000 + prevSel, expFrames);
      end
      DrawX = 10'd1;
      step();
      total++;
      if (rom_addr !== 21'(1000 + expSel[t])) begin
        bad++;
        $display("FAIL sel_addr_%0d got=%0d exp=%0d", t, rom_addr, 1000 + expSel[t]);
      end
      prevSel = expSel[t];
    end
    dead = 1'b0; jumping = 1'b0; keycode = 4'h0;
    DrawX = 10'd0; DrawY = 10'd0;
    for (int i = 0; i < 300; i++) begin
      step();
      expFrames++;
    end
    DrawX = 10'd3;
    total++;
    if (dut.frameCnt !== expFrames) begin
      bad++; $display("FAIL frame_wrap got=%0d exp=%0d", dut.frameCnt, expFrames);
    end
  endtask

  task automatic test_mid_reset();
    src_on = 4'hF;
    for (int i = 0; i < 4; i++) setAddr(i, 21'd100);
    dead = 1'b1; DrawX = 10'd30; DrawY = 10'd40;
    step();
    DrawX = 10'd0; DrawY = 10'd0;
    step();
    DrawX = 10'd30; DrawY = 10'd40;
    for (int i = 0; i < 4; i++) step();
    total++;
    if (pix_on !== 1'b1 || sel_state !== 2'd3) begin
      bad++; $display("FAIL pre_reset got on=%b sel=%0d exp on=1 sel=3", pix_on, sel_state);
    end
    Reset = 1'b1;
    step();
    total++;
    if (pix_on !== 1'b0 || sel_state !== 2'd0 || dut.frameCnt !== 8'd0 || rom_addr !== 21'd0) begin
      bad++;
      $display("FAIL mid_reset got on=%b sel=%0d fc=%0d addr=%0d exp all 0",
               pix_on, sel_state, dut.frameCnt, rom_addr);
    end
    Reset = 1'b0; dead = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if (pix_on !== 1'b0) begin
        bad++; $display("FAIL mid_reset_flush cyc=%0d got=%b exp=0", i, pix_on);
      end
    end
    step();
    total++;
    if (pix_on !== 1'b1 || pix_x !== 10'd30) begin
      bad++; $display("FAIL mid_reset_resume got on=%b x=%0d exp on=1 x=30", pix_on, pix_x);
    end
  endtask

  task automatic test_blink();
    logic [3:0] fi;
    logic       expOn;
    Reset = 1'b1;
    step();
    Reset = 1'b0; invincible = 1'b1; src_on = 4'hF;
    for (int f = 0; f < 16; f++) begin
      fi = 4'(f);
`ifdef PLAYER_BLINK_EN
      expOn = !fi[2];
`else
      expOn = 1'b1;
`endif
      DrawX = 10'd7; DrawY = 10'd3;
      for (int i = 0; i < 5; i++) step();
      total++;
      if (pix_on !== expOn) begin
        bad++; $display("FAIL blink_frame_%0d got=%b exp=%b", fi, pix_on, expOn);
      end
      DrawX = 10'd0; DrawY = 10'd0;
      step();
    end
    invincible = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; DrawX = '0; DrawY = '0; keycode = '0; jumping = 1'b0; dead = 1'b0;
    invincible = 1'b0; src_on = '0; src_addr = '0; expFrames = '0;
    @(negedge frame_Clk);
    test_reset();
    test_latency();
    test_back_to_back();
    test_frame_select();
    test_mid_reset();
    test_blink();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
